// File: rtl/seq_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_stream_ctrl                                                 |
// | Purpose  : Round-robin arbiter that serialises requester words into a      |
// |            bit-serial sequence detector and counts its match pulses.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_stream_ctrl #(
  parameter int WORD_W  = 18,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8,
  parameter int DET_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [WORD_W-1:0] word0,
  input  logic [WORD_W-1:0] word1,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              det_clr,
  output logic              det_din,
  output logic              det_vld,
  input  logic              det_result,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  hit_cnt
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_CLR   = 3'd1;
  localparam logic [2:0] c_SHIFT = 3'd2;
  localparam logic [2:0] c_DRAIN = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  localparam int                 c_LAT_W    = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;
  localparam logic [c_LAT_W-1:0] c_LAT_LOAD = c_LAT_W'(DET_LAT - 1);
  localparam logic [LEN_W-1:0]   c_WORD_LEN = LEN_W'(WORD_W);

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic               r_last;
  logic               r_owner;
  logic [WORD_W-1:0]  r_shift;
  logic [LEN_W-1:0]   r_bits;
  logic [c_LAT_W-1:0] r_lat;
  logic [CNT_W-1:0]   r_hits;
  logic [CNT_W-1:0]   w_hits_nxt;

  logic               w_any_req;
  logic               w_win;
  logic               w_start;
  logic [WORD_W-1:0]  w_word;
  logic [LEN_W-1:0]   w_len;
  logic [LEN_W-1:0]   w_len_eff;
  logic [LEN_W-1:0]   w_shamt;

  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_det_clr;
  logic               w_det_din;
  logic               w_det_vld;
  logic               w_busy;
  logic               w_done;

  // A tie goes to whichever requester was not granted last.
  assign w_any_req = req0 | req1;
  assign w_win     = (req0 && req1) ? ~r_last : req1;
  assign w_word    = w_win ? word1 : word0;
  assign w_len     = w_win ? len1 : len0;
  assign w_len_eff = ((w_len == '0) || (w_len > c_WORD_LEN)) ? c_WORD_LEN : w_len;
  assign w_shamt   = c_WORD_LEN - w_len_eff;
  assign w_start   = (r_state == c_IDLE) && (w_state_nxt == c_CLR);

  always_comb begin
    w_hits_nxt = r_hits;
    if (((r_state == c_SHIFT) || (r_state == c_DRAIN)) && det_result && (r_hits != '1))
      w_hits_nxt = r_hits + CNT_W'(1);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_any_req) w_state_nxt = c_CLR;
      c_CLR:   w_state_nxt = c_SHIFT;
      c_SHIFT: if (r_bits == '0) w_state_nxt = c_DRAIN;
      c_DRAIN: if (r_lat == '0) w_state_nxt = c_DONE;
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Output decode looks at the next state so every output leaves a flop.
  always_comb begin
    w_gnt0    = w_start && !w_win;
    w_gnt1    = w_start && w_win;
    w_det_clr = (w_state_nxt == c_CLR);
    w_det_vld = (w_state_nxt == c_SHIFT);
    w_det_din = (w_state_nxt == c_SHIFT) ? r_shift[WORD_W-1] : 1'b0;
    w_busy    = (w_state_nxt != c_IDLE);
    w_done    = (w_state_nxt == c_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_shift <= '0;
      r_bits  <= '0;
      r_lat   <= '0;
      r_hits  <= '0;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      det_clr <= 1'b0;
      det_din <= 1'b0;
      det_vld <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      hit_cnt <= '0;
    end else begin
      gnt0    <= w_gnt0;
      gnt1    <= w_gnt1;
      det_clr <= w_det_clr;
      det_din <= w_det_din;
      det_vld <= w_det_vld;
      busy    <= w_busy;
      done    <= w_done;

      if (w_start) begin
        r_shift <= w_word << w_shamt;
        r_bits  <= w_len_eff;
        r_hits  <= '0;
        r_owner <= w_win;
        r_last  <= w_win;
      end else begin
        r_hits <= w_hits_nxt;
        if (w_state_nxt == c_SHIFT) begin
          r_shift <= r_shift << 1;
          r_bits  <= r_bits - LEN_W'(1);
        end
      end

      if ((r_state == c_SHIFT) && (w_state_nxt == c_DRAIN))
        r_lat <= c_LAT_LOAD;
      else if ((r_state == c_DRAIN) && (r_lat != '0))
        r_lat <= r_lat - c_LAT_W'(1);

      if (w_state_nxt == c_DONE) begin
        done_id <= r_owner;
        hit_cnt <= w_hits_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_stream_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_stream_ctrl                                              |
// | Purpose  : Directed bench for seq_stream_ctrl with behavioural "1011"     |
// |            detectors (latency 1); a CNT_W=2 copy covers saturation.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_seq_stream_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [17:0] word0, word1;
  logic [4:0]  len0, len1;

  logic       gnt0, gnt1, det_clr, det_din, det_vld, det_result, busy, done, done_id;
  logic [7:0] hit_cnt;

  logic       gnt0_s, gnt1_s, det_clr_s, det_din_s, det_vld_s, det_result_s, busy_s, done_s, done_id_s;
  logic [1:0] hit_cnt_s;

  logic [2:0] dsh, dsh_s;

  int n_total = 0;
  int n_pass  = 0;
  int clr_pulses = 0;
  logic excl_err = 1'b0;
  logic vld_err  = 1'b0;

  always #5 clk = ~clk;

  seq_stream_ctrl #(.WORD_W(18), .LEN_W(5), .CNT_W(8), .DET_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .word0(word0), .word1(word1),
    .len0(len0), .len1(len1), .gnt0(gnt0), .gnt1(gnt1), .det_clr(det_clr),
    .det_din(det_din), .det_vld(det_vld), .det_result(det_result), .busy(busy),
    .done(done), .done_id(done_id), .hit_cnt(hit_cnt)
  );

  seq_stream_ctrl #(.WORD_W(18), .LEN_W(5), .CNT_W(2), .DET_LAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .word0(word0), .word1(word1),
    .len0(len0), .len1(len1), .gnt0(gnt0_s), .gnt1(gnt1_s), .det_clr(det_clr_s),
    .det_din(det_din_s), .det_vld(det_vld_s), .det_result(det_result_s), .busy(busy_s),
    .done(done_s), .done_id(done_id_s), .hit_cnt(hit_cnt_s)
  );

  // Overlapping "1011" detectors with one cycle of result latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsh <= '0; det_result <= 1'b0;
    end else if (det_clr) begin
      dsh <= '0; det_result <= 1'b0;
    end else if (det_vld) begin
      dsh <= {dsh[1:0], det_din};
      det_result <= ({dsh, det_din} == 4'b1011);
    end else begin
      det_result <= 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsh_s <= '0; det_result_s <= 1'b0;
    end else if (det_clr_s) begin
      dsh_s <= '0; det_result_s <= 1'b0;
    end else if (det_vld_s) begin
      dsh_s <= {dsh_s[1:0], det_din_s};
      det_result_s <= ({dsh_s, det_din_s} == 4'b1011);
    end else begin
      det_result_s <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt0 && gnt1) excl_err <= 1'b1;
      if (det_vld && (det_clr || done || !busy)) vld_err <= 1'b1;
      if (det_clr) clr_pulses <= clr_pulses + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at a negedge while the DUT is idle; returns at the negedge showing done.
  task automatic run_job(input string tag, input logic r0, input logic r1, input logic id,
                         input logic hold, input logic [17:0] exp_stream, input int n,
                         input int hits, input int hits_sat);
    req0 = r0;
    req1 = r1;
    chk({tag, "_idle_busy"}, {31'd0, busy}, 0);
    chk({tag, "_idle_gnt"}, {30'd0, gnt1, gnt0}, 0);
    @(negedge clk);
    chk({tag, "_gnt"}, {30'd0, gnt1, gnt0}, id ? 32'd2 : 32'd1);
    chk({tag, "_clr"}, {30'd0, det_clr, det_vld}, 32'd2);
    chk({tag, "_busy"}, {31'd0, busy}, 1);
    if (!hold) begin
      if (id) req1 = 1'b0;
      else    req0 = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_bit"}, {30'd0, det_vld, det_din}, {30'd0, 1'b1, exp_stream[17-i]});
    end
    @(negedge clk);
    chk({tag, "_drain"}, {29'd0, det_vld, det_din, done}, 0);
    @(negedge clk);
    chk({tag, "_done"}, {30'd0, done, done_s}, 32'd3);
    chk({tag, "_done_id"}, {30'd0, done_id, done_id_s}, id ? 32'd3 : 32'd0);
    chk({tag, "_hits"}, {24'd0, hit_cnt}, hits);
    chk({tag, "_hits_sat"}, {30'd0, hit_cnt_s}, hits_sat);
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    word0 = '0; word1 = '0;
    len0 = '0;  len1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {24'd0, gnt0, gnt1, det_clr, det_din, det_vld, busy, done, done_id}, 0);
    chk("rst_hits", {22'd0, hit_cnt, hit_cnt_s}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ctrl", {24'd0, gnt0, gnt1, det_clr, det_din, det_vld, busy, done, done_id}, 0);

    // Single job: 1011011 -> two overlapping matches
    word0 = 18'b1011011; len0 = 5'd7;
    run_job("single", 1'b1, 1'b0, 1'b0, 1'b0, {7'b1011011, 11'b0}, 7, 2, 2);

    // Length clamp on requester 1
    @(negedge clk);
    word1 = 18'h3FFFF; len1 = 5'd0;
    run_job("clamp0", 1'b0, 1'b1, 1'b1, 1'b0, 18'h3FFFF, 18, 0, 0);
    @(negedge clk);
    len1 = 5'd31;
    run_job("clamp31", 1'b0, 1'b1, 1'b1, 1'b0, 18'h3FFFF, 18, 0, 0);

    // Tie held for four jobs; last grant was 1, so order is 0,1,0,1
    @(negedge clk);
    word0 = 18'b10110;     len0 = 5'd5;
    word1 = 18'b101101011; len1 = 5'd9;
    run_job("tie_a", 1'b1, 1'b1, 1'b0, 1'b1, {5'b10110, 13'b0}, 5, 1, 1);
    @(negedge clk);
    run_job("tie_b", 1'b1, 1'b1, 1'b1, 1'b1, {9'b101101011, 9'b0}, 9, 2, 2);
    @(negedge clk);
    run_job("tie_c", 1'b1, 1'b1, 1'b0, 1'b1, {5'b10110, 13'b0}, 5, 1, 1);
    @(negedge clk);
    run_job("tie_d", 1'b1, 1'b1, 1'b1, 1'b1, {9'b101101011, 9'b0}, 9, 2, 2);
    req0 = 1'b0; req1 = 1'b0;

    // Job A ends in 101, job B starts with 1: the clear must stop a cross-job hit
    @(negedge clk);
    word0 = 18'b0101; len0 = 5'd4;
    run_job("clr_a", 1'b1, 1'b0, 1'b0, 1'b0, {4'b0101, 14'b0}, 4, 0, 0);
    @(negedge clk);
    word1 = 18'b100; len1 = 5'd3;
    run_job("clr_b", 1'b0, 1'b1, 1'b1, 1'b0, {3'b100, 15'b0}, 3, 0, 0);

    // Five matches: 8-bit counter reports 5, 2-bit counter saturates at 3
    @(negedge clk);
    word0 = 18'b1011011011011011; len0 = 5'd16;
    run_job("sat", 1'b1, 1'b0, 1'b0, 1'b0, {16'b1011011011011011, 2'b0}, 16, 5, 3);

    // Reset at the third valid bit of a job
    @(negedge clk);
    word0 = 18'b1011; len0 = 5'd4;
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_vld", {31'd0, det_vld}, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctrl", {24'd0, gnt0, gnt1, det_clr, det_din, det_vld, busy, done, done_id}, 0);
    chk("midrst_hits", {22'd0, hit_cnt, hit_cnt_s}, 0);
    req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run_job("post_rst", 1'b1, 1'b1, 1'b0, 1'b1, {4'b1011, 14'b0}, 4, 1, 1);
    req0 = 1'b0; req1 = 1'b0;

    repeat (3) @(negedge clk);
    chk("clr_pulses", clr_pulses, 12);
    chk("gnt_excl", {31'd0, excl_err}, 0);
    chk("vld_window", {31'd0, vld_err}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seq_stream_ctrl.md
# seq_stream_ctrl

Arbitrating stream controller for the bit-serial sequence detector. It accepts parallel words from two requesters and grants them round-robin. It clears the detector, shifts the granted word MSB-first onto the detector's `din`/`din_vld` inputs, and counts detector `result` pulses. Each job ends with a done pulse that reports the requester ID and the hit count. The block sits between software/stimulus sources and `seq_detect`, so several sources can share one detector instance.

## Interface
- `WORD_W`, 18: maximum stream length in bits; width of word inputs.
- `LEN_W`, 5: width of length inputs; must satisfy 2^LEN_W > WORD_W.
- `CNT_W`, 8: width of the hit counter.
- `DET_LAT`, 1: detector result latency in cycles after the last valid bit; must be ≥1.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req0`, `req1` in 1: request from requester 0/1; held until its grant.
- `word0`, `word1` in WORD_W: bits to stream; held with the request.
- `len0`, `len1` in LEN_W: number of bits to stream, 1..WORD_W. A value of 0 or any value above WORD_W is treated as WORD_W.
- `gnt0`, `gnt1` out 1: one-cycle grant pulse.
- `det_clr` out 1: synchronous clear to the detector.
- `det_din` out 1: serial bit to the detector.
- `det_vld` out 1: `det_din` is valid.
- `det_result` in 1: detector match pulse.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle job-complete pulse.
- `done_id` out 1: requester served; held until the next `done`.
- `hit_cnt` out CNT_W: matches counted in the last job; held until the next `done`.

## Operation
- **FSM states:** IDLE → CLR → SHIFT → DRAIN → DONE → IDLE. All outputs are registered.
- **IDLE:**
  - If any request is pending, pick the winner.
  - If only one requester is asserting, it wins.
  - If both are asserting, the requester not granted last wins. The last-grant register resets to 1, so requester 0 wins the first tie.
  - On the transition edge into CLR:
    - load the shift register with the winner's word left-aligned (`word << (WORD_W-len_eff)`);
    - load the bit counter with `len_eff`;
    - clear the hit counter;
    - record the owner.
- **CLR (1 cycle):**
  - The winner's `gnt` is high; `det_clr=1`; `det_vld=0`.
  - `det_result` is ignored in this cycle.
- **SHIFT (`len_eff` cycles):**
  - `det_vld=1`; `det_din` equals the shift register MSB.
  - The shift register shifts left and the bit counter decrements each cycle.
  - Exit to DRAIN when the counter reaches 0.
- **DRAIN (DET_LAT cycles):**
  - `det_vld=0` and `det_din=0`.
  - Catches results that lag the final bit.
- **Hit counting:**
  - In SHIFT and DRAIN, each cycle with `det_result=1` increments the hit counter.
  - The counter saturates at 2^CNT_W−1 and never wraps.
- **DONE (1 cycle):**
  - `done=1`.
  - `done_id` and `hit_cnt` update at the same edge as `done`.
  - Then return to IDLE. Arbitration resumes on the next cycle.
- **Requests outside IDLE:** ignored. Requests are not queued beyond the level-held `req`. A requester must drop `req` after its grant or it is served again.
- **Reset (any state, including mid-stream):**
  - FSM goes to IDLE.
  - `gnt0`, `gnt1`, `det_clr`, `det_din`, `det_vld`, `busy`, `done`, `done_id`, `hit_cnt`, the shift register and the counters all go to 0.
  - Last-grant register goes to 1.
  - The detector is not cleared by this block on reset; the detector shares `rst_n`.

## Timing
- **Request to grant:** `req` seen in IDLE at cycle T gives `gnt` and `det_clr` at T+1, and the first valid bit at T+2.
- **Last bit:** the last valid bit is at T+1+`len_eff`.
- **Done:** `done` is at T+2+`len_eff`+DET_LAT.
- **Next arbitration:** IDLE again at T+3+`len_eff`+DET_LAT.
- **Back-to-back jobs:** minimum spacing between two grants is `len_eff`+DET_LAT+3 cycles.
- **Exclusivity:** `gnt0` and `gnt1` are never high together. `det_vld` is never high in CLR, DRAIN, DONE or IDLE.

## Test plan
Bench uses a behavioural detector for overlapping "1011" with result latency DET_LAT=1.

- **Single job:** reset, then `req0` with `word0=7'b1011011` and `len0=7` → `gnt0` 1 cycle; `det_din` sequence is 1,0,1,1,0,1,1 with `det_vld` high for exactly 7 cycles; `done` 10 cycles after `req` is seen; `done_id=0`; `hit_cnt=2`.
- **Round-robin on tie:** `req0` and `req1` held high together for 4 jobs → grant order 0,1,0,1; `hit_cnt` is correct for each word; grants are spaced exactly `len`+4 cycles apart.
- **Length clamp:** `len1=0` and `len1=31`, each with an all-ones 18-bit word → 18 valid bits each; `hit_cnt=0`.
- **Clear between owners:** job A ends in "101", job B starts with "1" → no hit across the boundary; `det_clr` pulses once per job.
- **Saturation:** CNT_W=2 and a word containing 5 matches → `hit_cnt=3`.
- **Reset mid-SHIFT:** assert `rst_n`=0 at bit 3 → all outputs 0 within the reset; after release, a pending `req1` and `req0` tie grants `req0` first.
